// File: rtl/rf_port_sched_pkg.sv
// rf_port_sched_pkg
//   Shared constants and types for the register-file port scheduler:
//   default data/index widths, register count, the hard-wired zero register
//   and the RUN/FLUSH state encoding.
package rf_port_sched_pkg;

   localparam int DATA_W     = 32;
   localparam int RF_REG_W   = 5;
   localparam int RF_REG_NUM = 1 << RF_REG_W;

   // r0 reads as zero and is never written
   localparam logic [RF_REG_W-1:0] ZERO_REG = '0;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } sched_state_e;

endpackage

// File: rtl/rf_wr_queue.sv
// rf_wr_queue
//   Circular FIFO of {addr, data} writeback entries.
//   Ports:
//     clk, reset        clock, synchronous active-high reset (empties queue)
//     push, push_ent    enqueue an entry (caller guarantees not full)
//     pop               dequeue the head (caller guarantees not empty)
//     head_ent          current head entry
//     count/full/empty  occupancy
//     age_ent/age_vld   all entries in age order (index 0 = oldest) with
//                       valid bits, for the parallel bypass compare
module rf_wr_queue #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 push,
   input  logic [ADDR_W+DATA_W-1:0]             push_ent,
   input  logic                                 pop,
   output logic [ADDR_W+DATA_W-1:0]             head_ent,
   output logic [$clog2(DEPTH):0]               count,
   output logic                                 full,
   output logic                                 empty,
   output logic [DEPTH-1:0][ADDR_W+DATA_W-1:0]  age_ent,
   output logic [DEPTH-1:0]                     age_vld
);
   localparam int PW = $clog2(DEPTH);
   localparam int EW = ADDR_W + DATA_W;

   logic [DEPTH-1:0][EW-1:0] mem;
   logic [PW-1:0]            wr_ptr;
   logic [PW-1:0]            rd_ptr;

   // DEPTH is a power of two, so pointer overflow is the modulo wrap
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_ent;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign head_ent = mem[rd_ptr];
   assign full     = (count == (PW+1)'(DEPTH));
   assign empty    = (count == '0);

   // rotate storage so the bypass logic sees oldest..youngest
   for (genvar i = 0; i < DEPTH; i++) begin : g_age
      assign age_ent[i] = mem[rd_ptr + PW'(i)];
      assign age_vld[i] = ((PW+1)'(i) < count);
   end

endmodule

// File: rtl/rf_port_sched.sv
// rf_port_sched
//   Schedules the single shared access slot of reg_file: each cycle is
//   either one two-operand read or one write. Writebacks are buffered in
//   rf_wr_queue and bypassed to reads; a flush drains the queue.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     iRdReq/iRdAddr1/iRdAddr2   decode read request, oRdReady accepts
//     oRdValid/oRdData1/2        read result, one cycle after acceptance
//     iWbReq/iWbAddr/iWbData     writeback request, oWbReady accepts
//     iFlush/oFlushDone          drain request / completion pulse
//     oRf*                       reg_file slot controls
//     iRfReg1Data/iRfReg2Data    reg_file read data (valid the cycle after
//                                a read slot)
module rf_port_sched #(
   parameter int DATA_W       = rf_port_sched_pkg::DATA_W,
   parameter int RF_REG_W     = rf_port_sched_pkg::RF_REG_W,
   parameter int WQ_DEPTH     = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                iRdReq,
   input  logic [RF_REG_W-1:0] iRdAddr1,
   input  logic [RF_REG_W-1:0] iRdAddr2,
   output logic                oRdReady,
   output logic                oRdValid,
   output logic [DATA_W-1:0]   oRdData1,
   output logic [DATA_W-1:0]   oRdData2,
   input  logic                iWbReq,
   input  logic [RF_REG_W-1:0] iWbAddr,
   input  logic [DATA_W-1:0]   iWbData,
   output logic                oWbReady,
   input  logic                iFlush,
   output logic                oFlushDone,
   output logic [RF_REG_W-1:0] oRfReg1,
   output logic [RF_REG_W-1:0] oRfReg2,
   output logic [RF_REG_W-1:0] oRfWrReg3,
   output logic                oRfRegWr,
   output logic [DATA_W-1:0]   oRfWrData,
   input  logic [DATA_W-1:0]   iRfReg1Data,
   input  logic [DATA_W-1:0]   iRfReg2Data
);
   import rf_port_sched_pkg::*;

   localparam int EW = RF_REG_W + DATA_W;
   localparam int CW = $clog2(WQ_DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [RF_REG_W-1:0] R0 = RF_REG_W'(ZERO_REG);

   typedef struct packed {
      logic [RF_REG_W-1:0] addr;
      logic [DATA_W-1:0]   data;
   } wq_ent_t;

   typedef struct packed {
      logic              hit;
      logic [DATA_W-1:0] data;
   } byp_t;

   sched_state_e                 state, state_nxt;
   logic [CW-1:0]                q_count;
   logic                         q_full, q_empty;
   wq_ent_t                      q_head, q_push_ent;
   wq_ent_t [WQ_DEPTH-1:0]       q_age;
   logic [WQ_DEPTH-1:0]          q_age_vld;
   logic [SW-1:0]                starve;
   logic                         drain, rd_ready, flush_done;
   logic                         wb_ready, wb_acc, enq, rd_acc;
   byp_t                         byp1_c, byp2_c, byp1_q, byp2_q;
   logic                         rd_vld;
   logic [RF_REG_W-1:0]          reg1_q, reg2_q, wr_reg_q;
   logic [DATA_W-1:0]            wr_data_q;

   // youngest match wins: queue scanned oldest..youngest, then the
   // same-cycle write, then r0 overrides everything
   function automatic byp_t lookup(
      input logic [RF_REG_W-1:0]  a,
      input wq_ent_t [WQ_DEPTH-1:0] ents,
      input logic [WQ_DEPTH-1:0]  vld,
      input logic                 new_vld,
      input wq_ent_t              new_ent
   );
      byp_t r;
      r.hit  = 1'b0;
      r.data = '0;
      for (int i = 0; i < WQ_DEPTH; i++) begin
         if (vld[i] && ents[i].addr == a) begin
            r.hit  = 1'b1;
            r.data = ents[i].data;
         end
      end
      if (new_vld && new_ent.addr == a) begin
         r.hit  = 1'b1;
         r.data = new_ent.data;
      end
      if (a == R0) begin
         r.hit  = 1'b1;
         r.data = '0;
      end
      return r;
   endfunction

   rf_wr_queue #(
      .DATA_W (DATA_W),
      .ADDR_W (RF_REG_W),
      .DEPTH  (WQ_DEPTH)
   ) u_wq (
      .clk      (clk),
      .reset    (reset),
      .push     (enq),
      .push_ent (q_push_ent),
      .pop      (drain),
      .head_ent (q_head),
      .count    (q_count),
      .full     (q_full),
      .empty    (q_empty),
      .age_ent  (q_age),
      .age_vld  (q_age_vld)
   );

   // acceptance of a write ignores any same-cycle drain
   assign wb_ready   = !reset && !q_full;
   assign wb_acc     = iWbReq && wb_ready;
   assign enq        = wb_acc && (iWbAddr != R0);
   assign q_push_ent = {iWbAddr, iWbData};
   assign rd_acc     = iRdReq && rd_ready;

   always_comb begin
      state_nxt  = state;
      drain      = 1'b0;
      rd_ready   = 1'b0;
      flush_done = 1'b0;
      if (!reset) begin
         case (state)
            ST_RUN: begin
               drain    = !q_empty &&
                          (!iRdReq || q_full || starve >= SW'(STARVE_LIMIT));
               rd_ready = !drain;
               if (iFlush)
                  state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
               drain = !q_empty;
               // last entry leaving (or nothing left) with no new arrival
               if (!wb_acc && q_count <= CW'(1)) begin
                  flush_done = 1'b1;
                  state_nxt  = ST_RUN;
               end
            end
            default: state_nxt = ST_RUN;
         endcase
      end
   end

   always_comb begin
      byp1_c = lookup(iRdAddr1, q_age, q_age_vld, enq, q_push_ent);
      byp2_c = lookup(iRdAddr2, q_age, q_age_vld, enq, q_push_ent);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_RUN;
         starve    <= '0;
         rd_vld    <= 1'b0;
         byp1_q    <= '0;
         byp2_q    <= '0;
         reg1_q    <= '0;
         reg2_q    <= '0;
         wr_reg_q  <= '0;
         wr_data_q <= '0;
      end else begin
         state  <= state_nxt;
         rd_vld <= rd_acc;
         if (drain || q_empty)
            starve <= '0;
         else if (starve != SW'(STARVE_LIMIT))
            starve <= starve + 1'b1;
         if (rd_acc) begin
            byp1_q <= byp1_c;
            byp2_q <= byp2_c;
            reg1_q <= iRdAddr1;
            reg2_q <= iRdAddr2;
         end
         if (drain) begin
            wr_reg_q  <= q_head.addr;
            wr_data_q <= q_head.data;
         end
      end
   end

   assign oRdReady   = rd_ready;
   assign oWbReady   = wb_ready;
   assign oFlushDone = flush_done;
   assign oRdValid   = rd_vld && !reset;
   assign oRdData1   = oRdValid ? (byp1_q.hit ? byp1_q.data : iRfReg1Data) : '0;
   assign oRdData2   = oRdValid ? (byp2_q.hit ? byp2_q.data : iRfReg2Data) : '0;

   // idle slots hold the last driven addresses/data
   assign oRfRegWr  = drain;
   assign oRfReg1   = reset ? '0 : (rd_acc ? iRdAddr1 : reg1_q);
   assign oRfReg2   = reset ? '0 : (rd_acc ? iRdAddr2 : reg2_q);
   assign oRfWrReg3 = reset ? '0 : (drain ? q_head.addr : wr_reg_q);
   assign oRfWrData = reset ? '0 : (drain ? q_head.data : wr_data_q);

endmodule
